// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with byte write enables,
// optional write-to-read bypass, optional zero register and a scoreboard.
module register_file_sb #(
    parameter int register_num   = 32,
    parameter int register_width = 32,
    parameter int read_ports     = 2,
    parameter int zero_reg       = 1,
    parameter int bypass         = 1,
    parameter int addr_w         = $clog2(register_num)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [read_ports*addr_w-1:0]         rd_addr,
    output logic [read_ports*register_width-1:0] rd_data,
    output logic [read_ports-1:0]                rd_busy,
    input  logic                                 wr_en,
    input  logic [addr_w-1:0]                    wr_addr,
    input  logic [register_width/8-1:0]          wr_be,
    input  logic [register_width-1:0]            wr_data,
    input  logic                                 wr_clear,
    input  logic                                 rsv_en,
    input  logic [addr_w-1:0]                    rsv_addr,
    output logic                                 rsv_ok,
    output logic [register_num-1:0]              busy_mask
);

    localparam int nbytes = register_width / 8;

    logic [register_width-1:0] regs [register_num];
    logic [register_num-1:0]   pending;
    logic [register_num-1:0]   pend_next;
    logic                      wr_zero;
    logic                      clr_hit;
    logic                      set_hit;

    // Register 0 swallows writes, reservations and clears when hardwired.
    assign wr_zero = (zero_reg != 0) && (wr_addr == '0);
    assign clr_hit = wr_en && wr_clear;
    assign rsv_ok  = !pending[rsv_addr] || (clr_hit && (wr_addr == rsv_addr));
    assign set_hit = rsv_en && rsv_ok;

    assign busy_mask = pending;

    // Next pending bits: clear by retiring write, set by accepted reservation.
    always_comb begin
        pend_next = '0;
        for (int i = 0; i < register_num; i++) begin
            pend_next[i] = (pending[i] && !(clr_hit && (wr_addr == addr_w'(i))))
                         || (set_hit && (rsv_addr == addr_w'(i)));
        end
        if (zero_reg != 0) begin
            pend_next[0] = 1'b0;
        end
    end

    // Storage array: byte-masked write, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < register_num; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !wr_zero) begin
            for (int b = 0; b < nbytes; b++) begin
                if (wr_be[b]) begin
                    regs[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Scoreboard pending bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pend_next;
        end
    end

    genvar k;
    for (k = 0; k < read_ports; k++) begin : g_rd
        logic [addr_w-1:0]         ra;
        logic                      hit;
        logic [register_width-1:0] word;

        assign ra  = rd_addr[k*addr_w +: addr_w];
        assign hit = (bypass != 0) && wr_en && (wr_addr == ra);

        // Read mux with same-cycle merge of enabled write bytes.
        always_comb begin
            word = regs[ra];
            if (hit) begin
                for (int b = 0; b < nbytes; b++) begin
                    if (wr_be[b]) begin
                        word[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
            if ((zero_reg != 0) && (ra == '0)) begin
                word = '0;
            end
        end

        assign rd_data[k*register_width +: register_width] = word;
        assign rd_busy[k] = pending[ra] && !(hit && wr_clear);
    end

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed checks of register_file_sb with
// bypass enabled (dut) and disabled (dut_nb), driven in lockstep.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_clear;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ok, rsv_ok_nb;
    logic [31:0] busy_mask, busy_mask_nb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    register_file_sb #(.bypass(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .wr_clear(wr_clear),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .busy_mask(busy_mask)
    );

    register_file_sb #(.bypass(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .wr_clear(wr_clear),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_nb),
        .busy_mask(busy_mask_nb)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en    = 1'b0;
        wr_clear = 1'b0;
        wr_be    = 4'h0;
        rsv_en   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic clr);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        wr_clear = clr;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr  = '0;
        rsv_addr = '0;
        wr_addr  = '0;
        wr_data  = '0;
        tick();
        rst = 1'b0;
        #1;

        // reset state on every address, both ports
        for (int a = 0; a < 32; a++) begin
            rsv_addr = 5'(a);
            rd(5'(a), 5'(a));
            check("rst_rd", rd_data, 64'h0);
            check("rst_busy", {62'h0, rd_busy}, 64'h0);
            check("rst_ok", {63'h0, rsv_ok}, 64'h1);
        end
        check("rst_mask", {32'h0, busy_mask}, 64'h0);

        // reset clears written data
        wr(5'd5, 32'hDEADBEEF, 4'hF, 1'b0);
        tick();
        idle();
        rd(5'd5, 5'd5);
        check("r5_wr", rd_data, 64'hDEADBEEF_DEADBEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(5'd5, 5'd5);
        check("r5_rst", rd_data, 64'h0);

        // byte enables and bypass merge
        wr(5'd3, 32'h11223344, 4'hF, 1'b0);
        tick();
        wr(5'd3, 32'hAABBCCDD, 4'b0101, 1'b0);
        rd(5'd3, 5'd3);
        check("be_byp", {32'h0, rd_data[31:0]}, 64'h11BB33DD);
        check("be_nobyp", {32'h0, rd_data_nb[31:0]}, 64'h11223344);
        tick();
        idle();
        rd(5'd3, 5'd3);
        check("be_after", rd_data, 64'h11BB33DD_11BB33DD);
        check("be_after_nb", rd_data_nb, 64'h11BB33DD_11BB33DD);

        // zero register
        wr(5'd0, 32'hFFFFFFFF, 4'hF, 1'b1);
        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        rd(5'd0, 5'd0);
        check("r0_ok", {63'h0, rsv_ok}, 64'h1);
        check("r0_byp", rd_data, 64'h0);
        tick();
        idle();
        rd(5'd0, 5'd0);
        check("r0_rd", rd_data, 64'h0);
        check("r0_mask", {32'h0, busy_mask}, 64'h0);

        // reserve r7, second reservation refused
        rsv_en   = 1'b1;
        rsv_addr = 5'd7;
        #1;
        check("r7_ok1", {63'h0, rsv_ok}, 64'h1);
        tick();
        check("r7_mask", {32'h0, busy_mask}, 64'h80);
        check("r7_ok2", {63'h0, rsv_ok}, 64'h0);
        tick();
        idle();
        check("r7_drop", {32'h0, busy_mask}, 64'h80);
        rd(5'd7, 5'd7);
        check("r7_busy", {62'h0, rd_busy}, 64'h3);

        // retiring write on r7
        wr(5'd7, 32'h55, 4'hF, 1'b1);
        rd(5'd7, 5'd7);
        check("r7_clr_busy", {62'h0, rd_busy}, 64'h0);
        check("r7_clr_data", rd_data, 64'h55_00000055);
        check("r7_clr_busy_nb", {62'h0, rd_busy_nb}, 64'h3);
        check("r7_clr_data_nb", rd_data_nb, 64'h0);
        tick();
        idle();
        check("r7_mask0", {32'h0, busy_mask}, 64'h0);
        check("r7_mask0_nb", {32'h0, busy_mask_nb}, 64'h0);

        // plain write keeps pending unchanged
        wr(5'd9, 32'h1234, 4'hF, 1'b0);
        tick();
        idle();
        check("r9_plain", {32'h0, busy_mask}, 64'h0);
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        tick();
        idle();
        check("r9_rsv", {32'h0, busy_mask}, 64'h200);

        // clear and re-reserve r9 in the same cycle
        wr(5'd9, 32'hCAFE, 4'hF, 1'b1);
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        rd(5'd3, 5'd9);
        check("r9_ok", {63'h0, rsv_ok}, 64'h1);
        check("r9_ok_nb", {63'h0, rsv_ok_nb}, 64'h1);
        check("r9_busy", {62'h0, rd_busy}, 64'h0);
        check("r9_data", {32'h0, rd_data[63:32]}, 64'hCAFE);
        check("r9_busy_nb", {62'h0, rd_busy_nb}, 64'h2);
        check("r9_data_nb", {32'h0, rd_data_nb[63:32]}, 64'h1234);
        tick();
        idle();
        check("r9_mask", {32'h0, busy_mask}, 64'h200);
        check("r9_mask_nb", {32'h0, busy_mask_nb}, 64'h200);
        rd(5'd9, 5'd9);
        check("r9_held", rd_data, 64'hCAFE_0000CAFE);

        // clear on a non-pending register is a plain write
        wr(5'd4, 32'h77, 4'hF, 1'b1);
        tick();
        idle();
        check("r4_mask", {32'h0, busy_mask}, 64'h200);
        rd(5'd4, 5'd4);
        check("r4_data", rd_data, 64'h77_00000077);

        // clear with no byte enables retires without writing
        wr(5'd9, 32'hFFFFFFFF, 4'h0, 1'b1);
        tick();
        idle();
        check("r9_be0_mask", {32'h0, busy_mask}, 64'h0);
        rd(5'd9, 5'd9);
        check("r9_be0_data", rd_data, 64'hCAFE_0000CAFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised multi-port general-purpose register file with per-byte write enables, optional write-to-read bypass, optional hardwired-zero register 0, and an integrated scoreboard.
- The scoreboard tracks registers with outstanding writes from multi-cycle units such as loads, the multiplier and the divider.
- Sits between decode/issue (read ports, reservation) and writeback (write port, clear); replaces the fixed two-port word/byte register array in the CPU datapath.

Parameters:
register_num, 32, number of registers (power of two, >=2)
register_width, 32, register width in bits (multiple of 8)
read_ports, 2, number of independent combinational read ports (1..4)
zero_reg, 1, 1 = register 0 reads 0, ignores writes, is never pending
bypass, 1, 1 = same-cycle write data is forwarded to matching read ports
addr_w, $clog2(register_num), derived address width (not to be overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
rd_addr  input  read_ports*addr_w  packed read addresses, port k at [k*addr_w +: addr_w]
rd_data  output  read_ports*register_width  packed read data, port k at [k*register_width +: register_width]
rd_busy  output  read_ports  1 = port k's register has a pending write not resolved this cycle
wr_en  input  1  write strobe
wr_addr  input  addr_w  write destination
wr_be  input  register_width/8  byte enables, bit b covers data[8b+7:8b]
wr_data  input  register_width  write data
wr_clear  input  1  with wr_en: this write retires the pending reservation on wr_addr
rsv_en  input  1  request to mark rsv_addr pending
rsv_addr  input  addr_w  register to reserve
rsv_ok  output  1  combinational: reservation accepted this cycle
busy_mask  output  register_num  registered pending bit per register

Behaviour:
- Reset (rst=1 at posedge): all registers 0, all pending bits 0. Reset has priority over every write, reservation and clear in that cycle. After reset, rd_data=0, rd_busy=0, busy_mask=0, rsv_ok=1.
- Storage write: at posedge with wr_en=1, for each b with wr_be[b]=1, reg[wr_addr] byte b <= wr_data byte b. Other bytes are unchanged. wr_be=0 writes nothing; wr_clear still applies.
- Read: combinational, zero latency, from stored contents.
- bypass=1, port k, when wr_en=1 and wr_addr==rd_addr[k]: rd_data[k] = stored value with enabled bytes replaced by wr_data bytes.
- bypass=0: reads return pre-write contents; new data is visible the cycle after the edge.
- zero_reg=1: address 0 always reads 0, including the bypass path. Writes, reservations and clears to 0 have no effect. rsv_ok=1 when rsv_addr=0.
- Scoreboard: pending[i] is a registered bit.
  - set_hit = rsv_en & rsv_ok.
  - clr_hit = wr_en & wr_clear.
  - Next pending[i] = (pending[i] & ~(clr_hit & wr_addr==i)) | (set_hit & rsv_addr==i).
  - Set wins over clear on the same address, so the register is re-reserved.
- rsv_ok = ~pending[rsv_addr] | (clr_hit & wr_addr==rsv_addr). It does not depend on rsv_en.
- A reservation with rsv_ok=0 is dropped with no state change. The issuer must stall and retry.
- rd_busy[k] = pending[rd_addr[k]] & ~(bypass & clr_hit & wr_addr==rd_addr[k]).
  - With bypass, a retiring write resolves the hazard in the same cycle.
  - Without bypass, rd_busy stays 1 until the following cycle.
- wr_en without wr_clear: plain write (single-cycle ALU result); pending is unchanged.
- wr_clear on a non-pending register: the write occurs; pending stays 0 (no error).
- Multiple read ports on the same address return identical data and busy.

Test Plan:
- Reset, then read all addresses on all ports -> rd_data=0, busy_mask=0, rsv_ok=1. Write 0xDEADBEEF to r5, assert rst next cycle -> r5 reads 0.
- Write r3=0x11223344 with wr_be=1111, then wr_data=0xAABBCCDD with wr_be=0101 -> r3 reads 0x11BB33DD. With bypass=1, port 0 reads 0x11BB33DD during the second write cycle.
- zero_reg=1: write 0xFFFFFFFF to r0 with wr_be=1111, and reserve r0 -> r0 reads 0, busy_mask[0]=0, rsv_ok=1.
- rsv_en on r7 -> busy_mask[7]=1 next cycle. A second rsv_en on r7 -> rsv_ok=0 and is dropped. A read of r7 gives rd_busy=1.
- Pending r7: wr_en+wr_clear r7=0x55 -> same cycle with bypass=1: rd_busy=0, rd_data=0x55. Next cycle busy_mask[7]=0.
- Same cycle: clear r9 and reserve r9 -> rsv_ok=1, busy_mask[9]=1 after the edge, r9 holds the written data. Repeat with bypass=0 -> rd_busy=1 during the cycle, rd_data is the old value.
